// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: sums two WIDTH-bit operands LSB-first through a single
//   one-bit Full_Adder cell, with the carry held in a flop between bit steps.
//   An addition is issued with a start pulse and completes WIDTH cycles later
//   with a one-cycle done strobe. sum/cout are registered and hold the last
//   completed result until the next completion.
// ---------------------------------------------------------------------------

// One-bit full adder cell: purely combinational.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter wide enough to index bit steps 0..WIDTH-1 (WIDTH >= 2).
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;

    logic [WIDTH-1:0] a_sh_r;      // operand A, consumed from bit 0
    logic [WIDTH-1:0] b_sh_r;      // operand B, consumed from bit 0
    logic [WIDTH-1:0] psum_r;      // partial sum, filled from the MSB end
    logic             carry_r;     // carry between bit steps
    logic [CW-1:0]    cnt_r;       // index of the bit being processed

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    // -----------------------------------------------------------------------
    // Full adder cell and derived controls
    // -----------------------------------------------------------------------
    logic             fa_s;
    logic             fa_cout_s;
    logic             accept_s;    // a new operation is latched this edge
    logic             step_s;      // a bit step is performed this edge
    logic             last_step_s; // the final bit completes this edge
    logic [WIDTH-1:0] psum_nxt_s;  // partial sum after the current bit step

    Full_Adder u_fa (
        .A    (a_sh_r[0]),
        .B    (b_sh_r[0]),
        .Cin  (carry_r),
        .S    (fa_s),
        .Cout (fa_cout_s)
    );

    // Decode the accept / step / completion conditions from the current state.
    always_comb begin
        accept_s    = 1'b0;
        step_s      = 1'b0;
        last_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
            end
            RUN: begin
                // start is deliberately ignored while bits are in flight.
                step_s      = 1'b1;
                last_step_s = (cnt_r == CNT_LAST);
            end
            DONE: begin
                // Back-to-back: a start during the done cycle is taken directly.
                accept_s = start;
            end
            default: begin
                accept_s    = 1'b0;
                step_s      = 1'b0;
                last_step_s = 1'b0;
            end
        endcase
    end

    // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at bit 0.
    assign psum_nxt_s = {fa_s, psum_r[WIDTH-1:1]};

    // Next-state selection for the IDLE / RUN / DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to a safe idle state.
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shifters, carry flop and bit counter: load on accept, shift per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (accept_s) begin
            // Operands are captured here so later input changes cannot leak in.
            a_sh_r  <= a;
            b_sh_r  <= b;
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= cin;
            cnt_r   <= CNT_ZERO;
        end else if (step_s) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            psum_r  <= psum_nxt_s;
            carry_r <= fa_cout_s;
            cnt_r   <= cnt_r + CNT_ONE;
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            psum_r  <= psum_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result registers: updated only on the completion edge, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (last_step_s) begin
            // The final bit is folded in on the same edge it is produced.
            sum_r  <= psum_nxt_s;
            cout_r <= fa_cout_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    // Status flags registered from the next state so they align with it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            done_r <= (state_nxt_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: directed vector table at WIDTH=8,
//   multi-cycle corner sequences (held start, back-to-back, mid-run reset),
//   random operands against an arithmetic reference, and an exhaustive
//   sweep on a WIDTH=4 instance.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4;
    logic [3:0] sum4;
    logic       cout4;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Last completed result of dut8 as predicted by the bench (0 after reset).
    logic [7:0] prev_sum8  = 8'h00;
    logic       prev_cout8 = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one op on dut8 from a falling edge; return at the falling edge inside DONE.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input bit scramble,
                       input string tag);
        int k, nbusy, nhold;
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0; nbusy = 0; nhold = 0;
        start8 = scramble;
        if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        while (!done8 && k < 20) begin
            if (busy8) nbusy++;
            if (sum8 !== prev_sum8 || cout8 !== prev_cout8) nhold++;
            @(negedge clk);
            k++;
            start8 = scramble && (k < 7);
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
        end
        start8 = 1'b0;
        chk({tag, ":latency"},   32'(k),     32'd8);
        chk({tag, ":busy_len"},  32'(nbusy), 32'd8);
        chk({tag, ":hold"},      32'(nhold), 32'd0);
        chk({tag, ":done"},      32'(done8), 32'd1);
        chk({tag, ":busy_done"}, 32'(busy8), 32'd0);
        chk({tag, ":sum"},       32'(sum8),  32'(es));
        chk({tag, ":cout"},      32'(cout8), 32'(ec));
        prev_sum8  = es;
        prev_cout8 = ec;
    endtask

    // One cycle after DONE with no start: done dropped, back in IDLE.
    task automatic idle8(input string tag);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done8), 32'd0);
        chk({tag, ":idle_busy"},  32'(busy8), 32'd0);
        chk({tag, ":idle_sum"},   32'(sum8),  32'(prev_sum8));
    endtask

    // One op on dut4, left at the falling edge inside DONE.
    task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
        int k;
        logic [4:0] expv;
        expv = 5'(ia) + 5'(ib) + 5'(ic);
        a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("w4:latency", 32'(k), 32'd4);
        chk("w4:sum",  32'(sum4),  32'(expv[3:0]));
        chk("w4:cout", 32'(cout4), 32'(expv[4]));
    endtask

    initial begin
        int ndone;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rexp;

        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;

        tbl[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst:busy", 32'(busy8), 32'd0);
        chk("rst:done", 32'(done8), 32'd0);
        chk("rst:sum",  32'(sum8),  32'd0);
        chk("rst:cout", 32'(cout8), 32'd0);
        chk("rst:busy4", 32'(busy4), 32'd0);
        chk("rst:sum4",  32'(sum4),  32'd0);
        rst_n = 1'b1;

        // Directed table; entry 1 also checks that 0x7E/0 holds during its RUN.
        for (int i = 0; i < 6; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp_sum, tbl[i].exp_cout,
                1'b0, $sformatf("tbl%0d", i));
            idle8($sformatf("tbl%0d", i));
        end

        // Start held high with operands churning during RUN: no re-accept.
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "hold_start");
        idle8("hold_start");

        // Back-to-back: second start issued in the DONE cycle.
        op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0, "b2b_first");
        op8(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0, "b2b_second");
        idle8("b2b_second");

        // Reset pulsed at bit step 4 of a running op.
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort:busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort:busy", 32'(busy8), 32'd0);
        chk("abort:done", 32'(done8), 32'd0);
        chk("abort:sum",  32'(sum8),  32'd0);
        chk("abort:cout", 32'(cout8), 32'd0);
        prev_sum8 = 8'h00; prev_cout8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort:no_done", 32'(ndone), 32'd0);
        op8(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0, "after_abort");
        idle8("after_abort");

        // Random operands against plain arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, rexp[7:0], rexp[8], 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 1) idle8($sformatf("rand%0d", i));
        end

        // Exhaustive WIDTH=4 sweep, run back-to-back.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
